rtl_simple_datapath: RTL and testbench

- Register-transfer datapath driven by the simple RTL controller's per-cycle control word (op_sel, en_x, en_y, y_sel).
- Holds working registers x and y, a 4-function ALU, and carry/zero flags.
- On a commit strobe, pushes x into a 2-entry result FIFO drained by a downstream consumer over valid/ready.
- Sits directly downstream of the controller FSM and upstream of any result sink.

---
 rtl/rtl_simple_datapath_if.sv | 10 +
 rtl/rtl_simple_datapath.sv | 105 ++++++++++
 tb/tb_rtl_simple_datapath.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/rtl_simple_datapath_if.sv
// Result stream from the datapath to a downstream sink.
// Data and valid are driven by the datapath; ready comes from the consumer.
interface rtl_simple_datapath_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] res_data;
  logic             res_valid;
  logic             res_ready;

  modport master (output res_data, output res_valid, input res_ready);
  modport slave  (input res_data, input res_valid, output res_ready);
endinterface

// File: rtl/rtl_simple_datapath.sv
// Two-register ALU datapath (x, y) with carry/zero flags.
// A commit strobe pushes the pre-edge x into a 2-entry result FIFO.
module rtl_simple_datapath #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             op_sel,
  input  logic                   en_x,
  input  logic                   en_y,
  input  logic                   y_sel,
  input  logic [WIDTH-1:0]       din,
  input  logic                   commit,
  output logic [WIDTH-1:0]       x_out,
  output logic [WIDTH-1:0]       y_out,
  output logic                   carry,
  output logic                   zero,
  output logic                   overflow,
  rtl_simple_datapath_if.master  res
);

  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_carry;
  logic             r_overflow;
  logic [WIDTH-1:0] r_mem [2];
  logic             r_head;
  logic             r_tail;
  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_last;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_alu;
  logic             w_pop;
  logic             w_push;
  logic             w_full;

  assign w_sum = {1'b0, r_x} + {1'b0, r_y};

  always_comb begin
    w_alu = r_x;
    case (op_sel)
      2'd0: w_alu = r_x;
      2'd1: w_alu = ~r_x;
      2'd2: w_alu = w_sum[WIDTH-1:0];
      2'd3: w_alu = r_y;
      default: w_alu = r_x;
    endcase
  end

  assign w_full = (r_count == 2'd2);
  assign w_pop  = (r_count != 2'd0) && res.res_ready;
  assign w_push = commit && (!w_full || w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_carry <= 1'b0;
    end else begin
      if (en_x) begin
        r_x <= w_alu;
        if (op_sel == 2'd2) r_carry <= w_sum[WIDTH];
      end
      if (en_y) r_y <= y_sel ? din : w_alu;
    end
  end

  // r_last keeps the most recently popped word so res_data holds steady once empty
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_count    <= 2'd0;
      r_last     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= r_x;
        r_tail        <= ~r_tail;
      end
      if (w_pop) begin
        r_last <= r_mem[r_head];
        r_head <= ~r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (commit && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign x_out         = r_x;
  assign y_out         = r_y;
  assign carry         = r_carry;
  assign zero          = (r_x == '0);
  assign overflow      = r_overflow;
  assign res.res_valid = (r_count != 2'd0);
  assign res.res_data  = (r_count == 2'd0) ? r_last : r_mem[r_head];

endmodule

// File: tb/tb_rtl_simple_datapath.sv
// Directed bench for rtl_simple_datapath: ALU sequences, flag behaviour,
// result FIFO fill/drain/overflow and asynchronous reset.
module tb_rtl_simple_datapath;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       op_sel = 2'd0;
  logic             en_x = 1'b0;
  logic             en_y = 1'b0;
  logic             y_sel = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             commit = 1'b0;
  logic [WIDTH-1:0] x_out;
  logic [WIDTH-1:0] y_out;
  logic             carry;
  logic             zero;
  logic             overflow;

  int passed = 0;
  int total  = 0;

  rtl_simple_datapath_if #(.WIDTH(WIDTH)) res_if ();

  rtl_simple_datapath #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op_sel   (op_sel),
    .en_x     (en_x),
    .en_y     (en_y),
    .y_sel    (y_sel),
    .din      (din),
    .commit   (commit),
    .x_out    (x_out),
    .y_out    (y_out),
    .carry    (carry),
    .zero     (zero),
    .overflow (overflow),
    .res      (res_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // apply one control word, take one clock edge, then return to idle
  task automatic cyc(input logic [1:0] op, input logic ex, input logic ey,
                     input logic ys, input logic [WIDTH-1:0] d, input logic cm);
    op_sel = op; en_x = ex; en_y = ey; y_sel = ys; din = d; commit = cm;
    @(posedge clk);
    #1;
    op_sel = 2'd0; en_x = 1'b0; en_y = 1'b0; y_sel = 1'b0; din = '0; commit = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    res_if.res_ready = 1'b0;
    #12 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_x", x_out, 8'h00);
    chk("rst_y", y_out, 8'h00);
    chk("rst_carry", carry, 1'b0);
    chk("rst_zero", zero, 1'b1);
    chk("rst_valid", res_if.res_valid, 1'b0);
    chk("rst_data", res_if.res_data, 8'h00);
    chk("rst_ovf", overflow, 1'b0);

    // additive inverse of 5
    cyc(2'd0, 0, 1, 1, 8'h05, 0);
    chk("inv_y5", y_out, 8'h05);
    cyc(2'd3, 1, 0, 0, 8'h00, 0);
    chk("inv_x5", x_out, 8'h05);
    cyc(2'd1, 1, 0, 0, 8'h00, 0);
    chk("inv_notx", x_out, 8'hFA);
    cyc(2'd0, 0, 1, 1, 8'h01, 0);
    cyc(2'd2, 1, 0, 0, 8'h00, 0);
    chk("inv_neg5", x_out, 8'hFB);
    chk("inv_carry0", carry, 1'b0);
    cyc(2'd0, 0, 1, 1, 8'h05, 0);
    cyc(2'd2, 1, 0, 0, 8'h00, 0);
    chk("inv_sum0", x_out, 8'h00);
    chk("inv_zero", zero, 1'b1);
    chk("inv_carry1", carry, 1'b1);

    // wrap: 0xFF + 1
    cyc(2'd0, 0, 1, 1, 8'hFF, 0);
    cyc(2'd3, 1, 0, 0, 8'h00, 0);
    chk("wrap_xff", x_out, 8'hFF);
    chk("wrap_nz", zero, 1'b0);
    cyc(2'd0, 0, 1, 1, 8'h01, 0);
    cyc(2'd2, 1, 0, 0, 8'h00, 0);
    chk("wrap_x0", x_out, 8'h00);
    chk("wrap_carry", carry, 1'b1);
    chk("wrap_zero", zero, 1'b1);
    cyc(2'd1, 1, 0, 0, 8'h00, 0);
    chk("wrap_not", x_out, 8'hFF);
    chk("wrap_carry_hold", carry, 1'b1);
    cyc(2'd2, 0, 0, 0, 8'h00, 0);
    chk("idle_hold_x", x_out, 8'hFF);

    // simultaneous load, no forwarding
    cyc(2'd0, 0, 1, 1, 8'h03, 0);
    cyc(2'd3, 1, 0, 0, 8'h00, 0);
    cyc(2'd0, 0, 1, 1, 8'h04, 0);
    cyc(2'd2, 1, 1, 0, 8'h00, 0);
    chk("sim_x7", x_out, 8'h07);
    chk("sim_y7", y_out, 8'h07);
    chk("sim_carry0", carry, 1'b0);

    // FIFO fill to overflow with consumer stalled
    cyc(2'd0, 0, 1, 1, 8'h11, 0);
    cyc(2'd3, 1, 1, 1, 8'h22, 0);
    chk("fifo_x11", x_out, 8'h11);
    chk("fifo_empty", res_if.res_valid, 1'b0);
    cyc(2'd3, 1, 1, 1, 8'h33, 1);
    chk("fifo_valid1", res_if.res_valid, 1'b1);
    chk("fifo_head11", res_if.res_data, 8'h11);
    chk("fifo_x22", x_out, 8'h22);
    cyc(2'd3, 1, 0, 0, 8'h00, 1);
    chk("fifo_ovf0", overflow, 1'b0);
    cyc(2'd0, 0, 0, 0, 8'h00, 1);
    chk("fifo_ovf1", overflow, 1'b1);
    chk("fifo_head_stall", res_if.res_data, 8'h11);
    res_if.res_ready = 1'b1;
    cyc(2'd0, 0, 0, 0, 8'h00, 0);
    chk("drain_head22", res_if.res_data, 8'h22);
    chk("drain_valid", res_if.res_valid, 1'b1);
    cyc(2'd0, 0, 0, 0, 8'h00, 0);
    chk("drain_empty", res_if.res_valid, 1'b0);
    chk("drain_hold", res_if.res_data, 8'h22);
    chk("ovf_sticky", overflow, 1'b1);
    res_if.res_ready = 1'b0;

    do_reset();
    chk("rst2_ovf", overflow, 1'b0);

    // commit together with pop while full
    cyc(2'd0, 0, 1, 1, 8'hA1, 0);
    cyc(2'd3, 1, 1, 1, 8'hA2, 0);
    cyc(2'd3, 1, 1, 1, 8'hA3, 1);
    cyc(2'd3, 1, 0, 0, 8'h00, 1);
    chk("full_x", x_out, 8'hA3);
    chk("full_head", res_if.res_data, 8'hA1);
    res_if.res_ready = 1'b1;
    cyc(2'd0, 0, 0, 0, 8'h00, 1);
    chk("pp_ovf0", overflow, 1'b0);
    chk("pp_headA2", res_if.res_data, 8'hA2);
    cyc(2'd0, 0, 0, 0, 8'h00, 0);
    chk("pp_headA3", res_if.res_data, 8'hA3);
    chk("pp_valid", res_if.res_valid, 1'b1);
    cyc(2'd0, 0, 0, 0, 8'h00, 0);
    chk("pp_empty", res_if.res_valid, 1'b0);
    res_if.res_ready = 1'b0;

    // async reset between edges with FIFO full and overflow set
    cyc(2'd0, 0, 1, 1, 8'h5A, 1);
    cyc(2'd3, 1, 0, 0, 8'h00, 1);
    cyc(2'd0, 0, 0, 0, 8'h00, 1);
    chk("pre_x5a", x_out, 8'h5A);
    chk("pre_valid", res_if.res_valid, 1'b1);
    chk("pre_ovf", overflow, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_x", x_out, 8'h00);
    chk("arst_valid", res_if.res_valid, 1'b0);
    chk("arst_ovf", overflow, 1'b0);
    chk("arst_zero", zero, 1'b1);
    #3 reset_n = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
